// File: rtl/multi_pueo_beamform_sq_if.sv
// multi_pueo_beamform_sq_if: input word, mask configuration and square-stream bundle.
// pwr/pwr_valid exist only when BEAMFORM_POWER_SUM_EN is defined.
interface multi_pueo_beamform_sq_if #(
   parameter int NBEAMS = 4,
   parameter int NCHAN  = 8,
   parameter int NSAMP  = 4,
   parameter int NBITS  = 5
);
   localparam int SUMW = NBITS + 1 + $clog2(NCHAN);
   localparam int SQW  = 2 * SUMW - 2;
   localparam int BW   = NBEAMS > 1 ? $clog2(NBEAMS) : 1;
   localparam int PWW  = SQW + $clog2(NSAMP);
   logic [NCHAN*NSAMP*NBITS-1:0] dat;
   logic                         dat_valid;
   logic                         cfg_wr;
   logic [BW-1:0]                cfg_beam;
   logic [NCHAN-1:0]             cfg_use;
   logic [NCHAN-1:0]             cfg_invert;
   logic                         cfg_commit;
   logic                         cfg_ack;
   logic [NBEAMS*NSAMP*SQW-1:0]  sq;
   logic                         sq_valid;
   logic [15:0]                  sat_cnt;
`ifdef BEAMFORM_POWER_SUM_EN
   logic [NBEAMS*PWW-1:0]        pwr;
   logic                         pwr_valid;
   modport master (output dat, dat_valid, cfg_wr, cfg_beam, cfg_use, cfg_invert, cfg_commit,
                   input cfg_ack, sq, sq_valid, sat_cnt, pwr, pwr_valid);
   modport slave (input dat, dat_valid, cfg_wr, cfg_beam, cfg_use, cfg_invert, cfg_commit,
                  output cfg_ack, sq, sq_valid, sat_cnt, pwr, pwr_valid);
`else
   modport master (output dat, dat_valid, cfg_wr, cfg_beam, cfg_use, cfg_invert, cfg_commit,
                   input cfg_ack, sq, sq_valid, sat_cnt);
   modport slave (input dat, dat_valid, cfg_wr, cfg_beam, cfg_use, cfg_invert, cfg_commit,
                  output cfg_ack, sq, sq_valid, sat_cnt);
`endif
endinterface

// File: rtl/multi_pueo_beamform_sq.sv
// multi_pueo_beamform_sq: NBEAMS masked/inverted channel sums per sample, squared, latency 4.
// BEAMFORM_POWER_SUM_EN adds per-beam sum-of-squares outputs (pwr, pwr_valid) at latency 5.
module multi_pueo_beamform_sq #(
   parameter int NBEAMS = 4,
   parameter int NCHAN  = 8,
   parameter int NSAMP  = 4,
   parameter int NBITS  = 5
) (
   input logic                     clk,
   input logic                     rst_n,
   multi_pueo_beamform_sq_if.slave bus
);
   localparam int SUMW = NBITS + 1 + $clog2(NCHAN);
   localparam int SQW  = 2 * SUMW - 2;
   localparam int CW   = NBITS + 1;
   localparam int PW   = NBITS + 2;
   localparam int HALF = NCHAN / 2;
   localparam int MAXS = NCHAN * (2 ** NBITS - 1);

   logic [NCHAN-1:0]       sh_use  [NBEAMS];
   logic [NCHAN-1:0]       sh_inv  [NBEAMS];
   logic [NCHAN-1:0]       act_use [NBEAMS];
   logic [NCHAN-1:0]       act_inv [NBEAMS];
   logic signed [CW-1:0]   c1 [NBEAMS][NSAMP][NCHAN];
   logic signed [PW-1:0]   c2 [NBEAMS][NSAMP][HALF];
   logic signed [SUMW-1:0] c3 [NBEAMS][NSAMP];
   logic [NBEAMS-1:0]      wr;
   logic [2:0]             vld;

   // offset-binary x as 2x-(2^NBITS-1); inverting x negates the value
   function automatic logic signed [CW-1:0] chan(input logic [NBITS-1:0] x, input logic inv);
      logic [NBITS-1:0] v;
      v = inv ? ~x : x;
      return {v, 1'b1} - CW'(2 ** NBITS);
   endfunction

   function automatic logic signed [SUMW-1:0] tree(input int b, input int j);
      logic signed [SUMW-1:0] a;
      a = '0;
      for (int k = 0; k < HALF; k++) a = a + SUMW'(c2[b][j][k]);
      return a;
   endfunction

   function automatic logic [SQW-1:0] square(input logic signed [SUMW-1:0] s);
      logic signed [2*SUMW-1:0] p;
      p = (2*SUMW)'(s) * (2*SUMW)'(s);
      return p[SQW-1:0];
   endfunction

   function automatic logic at_max();
      logic m;
      m = 1'b0;
      for (int b = 0; b < NBEAMS; b++)
         for (int j = 0; j < NSAMP; j++)
            m = m | (c3[b][j] == SUMW'(MAXS)) | (c3[b][j] == -SUMW'(MAXS));
      return m;
   endfunction

   always_comb begin
      wr = '0;
      for (int b = 0; b < NBEAMS; b++) wr[b] = bus.cfg_wr && int'(bus.cfg_beam) == b;
   end

   // a write in the commit cycle reaches the active set directly
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         for (int b = 0; b < NBEAMS; b++) begin
            sh_use[b]  <= '0;
            sh_inv[b]  <= '0;
            act_use[b] <= '0;
            act_inv[b] <= '0;
         end
         bus.cfg_ack <= 1'b0;
      end else begin
         for (int b = 0; b < NBEAMS; b++) begin
            sh_use[b]  <= wr[b] ? bus.cfg_use : sh_use[b];
            sh_inv[b]  <= wr[b] ? bus.cfg_invert : sh_inv[b];
            act_use[b] <= bus.cfg_commit ? (wr[b] ? bus.cfg_use : sh_use[b]) : act_use[b];
            act_inv[b] <= bus.cfg_commit ? (wr[b] ? bus.cfg_invert : sh_inv[b]) : act_inv[b];
         end
         bus.cfg_ack <= bus.cfg_commit;
      end

   always_ff @(posedge clk)
      for (int b = 0; b < NBEAMS; b++)
         for (int j = 0; j < NSAMP; j++) begin
            for (int i = 0; i < NCHAN; i++)
               c1[b][j][i] <= act_use[b][i] ?
                  chan(bus.dat[NBITS*(NSAMP*i+j) +: NBITS], act_inv[b][i]) : '0;
            for (int k = 0; k < HALF; k++)
               c2[b][j][k] <= PW'(c1[b][j][2*k]) + PW'(c1[b][j][2*k+1]);
            c3[b][j] <= tree(b, j);
         end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         vld          <= '0;
         bus.sq       <= '0;
         bus.sq_valid <= 1'b0;
         bus.sat_cnt  <= '0;
      end else begin
         vld          <= {vld[1:0], bus.dat_valid};
         bus.sq_valid <= vld[2];
         if (vld[2])
            for (int b = 0; b < NBEAMS; b++)
               for (int j = 0; j < NSAMP; j++)
                  bus.sq[SQW*(NSAMP*b+j) +: SQW] <= square(c3[b][j]);
         if (vld[2] && at_max() && bus.sat_cnt != 16'hFFFF) bus.sat_cnt <= bus.sat_cnt + 16'd1;
      end

`ifdef BEAMFORM_POWER_SUM_EN
   localparam int PWW = SQW + $clog2(NSAMP);

   function automatic logic [PWW-1:0] psum(input int b);
      logic [PWW-1:0] a;
      a = '0;
      for (int j = 0; j < NSAMP; j++) a = a + PWW'(bus.sq[SQW*(NSAMP*b+j) +: SQW]);
      return a;
   endfunction

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         bus.pwr       <= '0;
         bus.pwr_valid <= 1'b0;
      end else begin
         bus.pwr_valid <= bus.sq_valid;
         for (int b = 0; b < NBEAMS; b++) bus.pwr[PWW*b +: PWW] <= psum(b);
      end
`endif
endmodule
